// File: rtl/motor_pkg.sv
// motor_pkg: definitions shared by the H-bridge drive stage and its
// helpers.
//   - motor_state_e : one-hot ramp FSM state encoding (5 bits)
//   - MOTOR_CNT_W   : default width of the PWM period counter and duty register
package motor_pkg;

    localparam int MOTOR_CNT_W = 16;

    // One-hot encoding keeps each state decode a single flop. Illegal
    // encodings fall back to STOP in the FSM.
    typedef enum logic [4:0] {
        ST_STOP      = 5'b00001,
        ST_RAMP_UP   = 5'b00010,
        ST_RUN       = 5'b00100,
        ST_RAMP_DOWN = 5'b01000,
        ST_DEAD      = 5'b10000
    } motor_state_e;

endpackage

// File: rtl/motor_drive_if.sv
// motor_drive_if: run request and bridge-drive bundle between the mode FSM
// and the H-bridge drive stage.
//   enable   : run request (mode FSM -> drive)
//   direct   : requested direction, 1 = clockwise (mode FSM -> drive)
//   pwm_a    : bridge leg A gate, clockwise (drive -> bridge)
//   pwm_b    : bridge leg B gate, counter-clockwise (drive -> bridge)
//   at_speed : drive is at full duty (drive -> mode FSM)
//   busy     : drive is anywhere but STOP (drive -> mode FSM)
// Modports: master = mode FSM side, slave = drive stage side.
interface motor_drive_if;

    logic enable;
    logic direct;
    logic pwm_a;
    logic pwm_b;
    logic at_speed;
    logic busy;

    modport master (
        output enable,
        output direct,
        input  pwm_a,
        input  pwm_b,
        input  at_speed,
        input  busy
    );

    modport slave (
        input  enable,
        input  direct,
        output pwm_a,
        output pwm_b,
        output at_speed,
        output busy
    );

endinterface

// File: rtl/pwm_counter.sv
// pwm_counter: free-running PWM period counter shared by the PWM stages.
//   sclk  : system clock
//   s_rst : synchronous active-high reset, clears the count
//   cnt   : current position in the period, 0 .. PWM_PERIOD-1
//   pe    : period end, high while cnt == PWM_PERIOD-1
// The counter wraps continuously and does not depend on any drive state.
module pwm_counter
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int CNT_W      = MOTOR_CNT_W
) (
    input  logic             sclk,
    input  logic             s_rst,
    output logic [CNT_W-1:0] cnt,
    output logic             pe
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of the others, as real hardware does.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign pe  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/motor_drive.sv
// motor_drive: H-bridge drive stage with soft-start / soft-stop duty ramps.
//   sclk  : system clock
//   s_rst : synchronous active-high reset; cuts drive on the same edge
//   bus   : motor_drive_if.slave
//           enable/direct in; pwm_a/pwm_b/at_speed/busy out (all registered)
// A direction change always runs ramp-down, DEAD_CYC fully-off periods,
// a STOP period, then ramp-up, so both legs are never driven together and
// the bridge never reverses abruptly. Duty, latched direction and every
// state transition only change at the period end, so a new duty always
// starts on a period boundary.
module motor_drive
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_MAX   = 800,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_CYC   = 4,
    parameter int CNT_W      = MOTOR_CNT_W
) (
    input  logic          sclk,
    input  logic          s_rst,
    motor_drive_if.slave  bus
);

    localparam int CNT_W1   = CNT_W + 1;
    localparam int DEAD_EFF = (DEAD_CYC < 1) ? 1 : DEAD_CYC;

    localparam logic [CNT_W-1:0]  DUTY_MAX_N = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]  STEP_N     = CNT_W'(RAMP_STEP);
    localparam logic [CNT_W-1:0]  START_DUTY = CNT_W'((RAMP_STEP < DUTY_MAX) ? RAMP_STEP : DUTY_MAX);
    localparam logic [CNT_W-1:0]  DEAD_LAST  = CNT_W'(DEAD_EFF - 1);
    localparam logic [CNT_W1-1:0] DUTY_MAX_W = CNT_W1'(DUTY_MAX);
    localparam logic [CNT_W1-1:0] STEP_W     = CNT_W1'(RAMP_STEP);

    logic [CNT_W-1:0] cnt;
    logic             pe;

    pwm_counter #(
        .PWM_PERIOD (PWM_PERIOD),
        .CNT_W      (CNT_W)
    ) u_pwm_counter (
        .sclk  (sclk),
        .s_rst (s_rst),
        .cnt   (cnt),
        .pe    (pe)
    );

    motor_state_e     state_q, state_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] dead_q, dead_d;
    logic             dir_lat_q, dir_lat_d;
    logic             pwm_a_q, pwm_a_d;
    logic             pwm_b_q, pwm_b_d;
    logic             at_speed_q, at_speed_d;
    logic             busy_q, busy_d;

    logic              dir_in;
    logic              rev;
    logic              pwm_on;
    logic [CNT_W1-1:0] duty_ext;
    logic [CNT_W1-1:0] duty_up;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        dead_d    = dead_q;
        dir_lat_d = dir_lat_q;

        // Only an unambiguous 1 means clockwise; z/x resolve to counter-clockwise.
        dir_in   = (bus.direct === 1'b1);
        rev      = (dir_in != dir_lat_q);
        // One extra bit so the ramp sums cannot wrap before the saturating compare.
        duty_ext = {1'b0, duty_q};
        duty_up  = duty_ext + STEP_W;

        if (pe) begin
            case (state_q)
                ST_STOP: begin
                    if (bus.enable) begin
                        dir_lat_d = dir_in;
                        duty_d    = START_DUTY;
                        state_d   = ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (!bus.enable || rev) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (duty_up >= DUTY_MAX_W) begin
                        duty_d  = DUTY_MAX_N;
                        state_d = ST_RUN;
                    end else begin
                        duty_d = duty_up[CNT_W-1:0];
                    end
                end
                ST_RUN: begin
                    if (!bus.enable || rev) begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_DOWN: begin
                    // Resuming keeps the current duty and ramps up from there.
                    if (bus.enable && !rev) begin
                        state_d = ST_RAMP_UP;
                    end else if (duty_ext <= STEP_W) begin
                        duty_d  = '0;
                        dead_d  = '0;
                        state_d = ST_DEAD;
                    end else begin
                        duty_d = duty_q - STEP_N;
                    end
                end
                ST_DEAD: begin
                    // Inputs are deliberately ignored until the dead time has elapsed.
                    duty_d = '0;
                    dead_d = dead_q + CNT_W'(1);
                    if (dead_q == DEAD_LAST) begin
                        state_d = ST_STOP;
                    end
                end
                default: begin
                    duty_d  = '0;
                    state_d = ST_STOP;
                end
            endcase
        end

        // Each leg is gated by the latched direction, so both can never be high.
        pwm_on  = (cnt < duty_q);
        pwm_a_d = pwm_on & dir_lat_q;
        pwm_b_d = pwm_on & ~dir_lat_q;

        // Status is decoded from the next state so it lines up with state_q.
        at_speed_d = (state_d == ST_RUN);
        busy_d     = (state_d != ST_STOP);
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q    <= ST_STOP;
            duty_q     <= '0;
            dead_q     <= '0;
            dir_lat_q  <= 1'b0;
            pwm_a_q    <= 1'b0;
            pwm_b_q    <= 1'b0;
            at_speed_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dead_q     <= dead_d;
            dir_lat_q  <= dir_lat_d;
            pwm_a_q    <= pwm_a_d;
            pwm_b_q    <= pwm_b_d;
            at_speed_q <= at_speed_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.pwm_a    = pwm_a_q;
    assign bus.pwm_b    = pwm_b_q;
    assign bus.at_speed = at_speed_q;
    assign bus.busy     = busy_q;

endmodule
